instr_fetch: RTL and testbench

Program-counter and instruction-fetch stage that sits directly upstream of the ALU/decode path. It holds the PC and fetches one instruction at a time from instruction memory over a req/ack handshake. It presents each instruction to decode with a valid/ready handshake. At each issue it takes the next PC from the ALU zero flag and the decoded branch controls: relative branch, absolute branch, or sequential.

---
 rtl/instr_fetch.sv | 95 +++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Program-counter and single-outstanding instruction fetch stage.
// Fetches over a req/ack port, issues to decode over valid/ready, and resolves the next PC at issue.
module instr_fetch #(
  parameter int              PC_W    = 10,
  parameter int              INSTR_W = 9,
  parameter int              OFS_W   = 8,
  parameter logic [PC_W-1:0] INIT_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_rel,
  input  logic               br_abs,
  input  logic               z,
  input  logic [OFS_W-1:0]   br_ofs,
  input  logic [PC_W-1:0]    br_tgt,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] pc_next;

  // Offset is sign-extended to PC width; wrap-around is intentional.
  assign pc_seq = pc + PC_W'(1);
  assign pc_rel = pc + PC_W'($signed(br_ofs));

  always_comb begin
    pc_next = pc_seq;
    if (br_abs && z)
      pc_next = br_tgt;
    else if (br_rel && z)
      pc_next = pc_rel;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= INIT_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc       <= INIT_PC;
            imem_req <= 1'b1;
            done     <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Branch/halt controls only matter on the handshake cycle.
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (halt) begin
              done  <= 1'b1;
              state <= HALT;
            end else begin
              pc       <= pc_next;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a behavioural next-PC model.
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       reset, start, imem_req, imem_ack, instr_valid, instr_ready;
  logic       br_rel, br_abs, z, halt, done;
  logic [9:0] imem_addr, br_tgt, pc;
  logic [8:0] imem_rdata, instr;
  logic [7:0] br_ofs;

  int checks = 0;
  int errors = 0;
  int ref_pc = 0;
  int obs_addr, obs_req_cyc, obs_val_cyc;
  bit obs_stable, obs_timeout;

  instr_fetch #(.PC_W(10), .INSTR_W(9), .OFS_W(8), .INIT_PC(10'd0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_rel(br_rel), .br_abs(br_abs), .z(z), .br_ofs(br_ofs), .br_tgt(br_tgt),
    .halt(halt), .pc(pc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Next PC from the architectural rules, in plain integer arithmetic.
  function automatic int model_next(int cur, bit h, bit ba, bit br, bit zz, int ofs8, int tgt);
    int ofs_s;
    if (h) return cur;
    if (ba && zz) return tgt;
    if (br && zz) begin
      ofs_s = (ofs8 >= 128) ? ofs8 - 256 : ofs8;
      return ((cur + ofs_s) % 1024 + 1024) % 1024;
    end
    return (cur + 1) % 1024;
  endfunction

  // Drives one fetch+issue from FETCH state and records what was observed.
  task automatic run_instr(input int data, input int ack_dly, input int rdy_dly,
                           input bit h, input bit ba, input bit br, input bit zz,
                           input int ofs, input int tgt);
    logic [8:0] d;
    d = data[8:0];
    obs_timeout = 0; obs_stable = 1; obs_req_cyc = 0; obs_val_cyc = 0;
    obs_addr = int'(imem_addr);
    while (imem_req === 1'b1 && obs_req_cyc < 20) begin
      obs_req_cyc++;
      imem_ack   = (obs_req_cyc == ack_dly + 1);
      imem_rdata = imem_ack ? d : 9'($urandom);
      start      = 1'($urandom);
      tick;
    end
    if (obs_req_cyc >= 20) obs_timeout = 1;
    imem_ack = 1'b0; imem_rdata = 9'($urandom);
    while (instr_valid === 1'b1 && obs_val_cyc < 20) begin
      obs_val_cyc++;
      if (instr !== d) obs_stable = 0;
      instr_ready = (obs_val_cyc == rdy_dly + 1);
      if (instr_ready) begin
        halt = h; br_abs = ba; br_rel = br; z = zz; br_ofs = ofs[7:0]; br_tgt = tgt[9:0];
      end else begin
        halt = 1'($urandom); br_abs = 1'($urandom); br_rel = 1'($urandom); z = 1'($urandom);
        br_ofs = 8'($urandom); br_tgt = 10'($urandom);
      end
      start = 1'($urandom);
      tick;
    end
    if (obs_val_cyc >= 20) obs_timeout = 1;
    instr_ready = 0; halt = 0; br_abs = 0; br_rel = 0; z = 0; start = 0;
    ref_pc = model_next(ref_pc, h, ba, br, zz, ofs, tgt);
  endtask

  task automatic test_reset;
    reset = 1; start = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 10'd0 || instr !== 9'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: pc=%h instr=%h req=%b valid=%b done=%b, need 0 0 0 0 0",
               pc, instr, imem_req, instr_valid, done);
    end
    start = 0; reset = 0;
    tick; tick;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: req=%b need 0", imem_req);
    end
    $display("reset: pc=%h req=%b done=%b", pc, imem_req, done);
  endtask

  task automatic test_sequential;
    start = 1; tick; start = 0;
    ref_pc = 0;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL start_to_req: req=%b need 1", imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      run_instr(int'($urandom_range(0, 511)), 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_addr != i || obs_req_cyc != 1 || obs_val_cyc != 1 || done !== 1'b0 || obs_timeout) begin
        errors++;
        $display("FAIL seq_fetch%0d: addr=%0d req_cyc=%0d val_cyc=%0d done=%b, need addr=%0d 1 1 0",
                 i, obs_addr, obs_req_cyc, obs_val_cyc, done, i);
      end
      $display("seq: fetch addr=%0d next=%0d", obs_addr, imem_addr);
    end
  endtask

  task automatic test_stalls;
    int prev;
    prev = ref_pc;
    run_instr(int'($urandom_range(0, 511)), 3, 2, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_req_cyc != 4 || obs_val_cyc != 3 || !obs_stable || obs_timeout) begin
      errors++;
      $display("FAIL stall_timing: req_cyc=%0d val_cyc=%0d stable=%b, need 4 3 1",
               obs_req_cyc, obs_val_cyc, obs_stable);
    end
    checks++;
    if (int'(imem_addr) != (prev + 1) % 1024 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_pc: addr=%h req=%b need %h 1", imem_addr, imem_req, 10'((prev + 1) % 1024));
    end
    $display("stall: req_cyc=%0d val_cyc=%0d next=%h", obs_req_cyc, obs_val_cyc, imem_addr);
  endtask

  task automatic test_branches;
    int t_ba[10]  = '{1, 0, 1, 0, 1, 1, 1, 0, 0, 1};
    int t_br[10]  = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 0};
    int t_z[10]   = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 0};
    int t_ofs[10] = '{0, 'hFC, 0, 'hFC, 0, 'h04, 0, 0, 'h80, 0};
    int t_tgt[10] = '{'h010, 0, 'h010, 0, 'h010, 'h2A0, 'h3FF, 0, 0, 'h100};
    int t_exp[10] = '{'h010, 'h00C, 'h010, 'h011, 'h010, 'h2A0, 'h3FF, 'h000, 'h380, 'h381};
    for (int i = 0; i < 10; i++) begin
      run_instr(int'($urandom_range(0, 511)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                0, t_ba[i][0], t_br[i][0], t_z[i][0], t_ofs[i], t_tgt[i]);
      checks++;
      if (int'(imem_addr) != t_exp[i] || imem_req !== 1'b1 || obs_timeout) begin
        errors++;
        $display("FAIL branch%0d: addr=%h req=%b need %h 1", i, imem_addr, imem_req, 10'(t_exp[i]));
      end
      $display("branch%0d: abs=%0d rel=%0d z=%0d ofs=%h -> %h", i, t_ba[i], t_br[i], t_z[i], t_ofs[i], imem_addr);
    end
  endtask

  task automatic test_random;
    int ad, rd, ofs, tgt, prev;
    bit ba, br, zz;
    for (int i = 0; i < 40; i++) begin
      ad = int'($urandom_range(0, 3)); rd = int'($urandom_range(0, 2));
      ba = 1'($urandom); br = 1'($urandom); zz = 1'($urandom);
      ofs = int'($urandom_range(0, 255)); tgt = int'($urandom_range(0, 1023));
      prev = ref_pc;
      checks++;
      if (int'(pc) != prev) begin
        errors++;
        $display("FAIL rnd_pc%0d: pc=%h need %h", i, pc, 10'(prev));
      end
      run_instr(int'($urandom_range(0, 511)), ad, rd, 0, ba, br, zz, ofs, tgt);
      checks++;
      if (obs_addr != prev || obs_req_cyc != ad + 1 || obs_val_cyc != rd + 1 || !obs_stable ||
          obs_timeout || int'(imem_addr) != ref_pc) begin
        errors++;
        $display("FAIL rnd%0d: addr=%h req_cyc=%0d val_cyc=%0d stable=%b next=%h, need %h %0d %0d 1 %h",
                 i, 10'(obs_addr), obs_req_cyc, obs_val_cyc, obs_stable, imem_addr,
                 10'(prev), ad + 1, rd + 1, 10'(ref_pc));
      end
      $display("rnd%0d: pc=%h abs=%b rel=%b z=%b ofs=%h tgt=%h -> %h", i, 10'(prev), ba, br, zz,
               8'(ofs), 10'(tgt), imem_addr);
    end
  endtask

  task automatic test_halt;
    run_instr(1, 0, 0, 0, 1, 0, 1, 0, 'h005);
    run_instr(2, 1, 1, 1, 1, 1, 1, 'h10, 'h222);
    checks++;
    if (done !== 1'b1 || pc !== 10'h005 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: done=%b pc=%h req=%b valid=%b need 1 005 0 0", done, pc, imem_req, instr_valid);
    end
    tick; tick;
    checks++;
    if (done !== 1'b1 || pc !== 10'h005 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: done=%b pc=%h req=%b need 1 005 0", done, pc, imem_req);
    end
    start = 1; tick; start = 0;
    ref_pc = 0;
    checks++;
    if (done !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h000) begin
      errors++;
      $display("FAIL halt_restart: done=%b req=%b addr=%h need 0 1 000", done, imem_req, imem_addr);
    end
    $display("halt: restart addr=%h done=%b", imem_addr, done);
  endtask

  task automatic test_reset_mid_fetch;
    run_instr(3, 0, 0, 0, 1, 0, 1, 0, 'h123);
    #2;
    imem_ack = 1'b1; imem_rdata = 9'h1AB;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 10'h000 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: req=%b pc=%h valid=%b need 0 000 0", imem_req, pc, instr_valid);
    end
    #3 reset = 1'b0;
    ref_pc = 0;
    tick; tick; tick;
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || done !== 1'b0 || instr !== 9'd0) begin
      errors++;
      $display("FAIL late_ack: valid=%b req=%b done=%b instr=%h need 0 0 0 000", instr_valid, imem_req, done, instr);
    end
    start = 1; tick; start = 0;
    run_instr(int'($urandom_range(0, 511)), 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_addr != 0 || imem_addr !== 10'h001 || obs_timeout) begin
      errors++;
      $display("FAIL reset_recover: addr=%0d next=%h need 0 001", obs_addr, imem_addr);
    end
    $display("reset_mid_fetch: recovered next=%h", imem_addr);
  endtask

  initial begin
    reset = 0; start = 0; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
    br_rel = 0; br_abs = 0; z = 0; br_ofs = 0; br_tgt = 0; halt = 0;
    #1;
    test_reset;
    test_sequential;
    test_stalls;
    test_branches;
    test_random;
    test_halt;
    test_reset_mid_fetch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
